// File: rtl/mips_fetch_pkg.sv
// Shared widths, fetch FSM state type and small address helpers for the
// instruction fetch unit and its prefetch buffer.
package mips_fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 8'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

    // Word alignment: low bits of a branch target are dropped, never rounded.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
        return addr & ~(PC_STEP - 8'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: strict FIFO of {instruction, pc} pairs with flush,
// simultaneous push/pop, and a zeroed head view when empty.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [INST_W-1:0] i_push_inst,
    input  logic [ADDR_W-1:0] i_push_pc,
    output logic [2:0]        o_count,
    output logic [INST_W-1:0] o_head_inst,
    output logic [ADDR_W-1:0] o_head_pc
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    logic [INST_W-1:0] r_inst [DEPTH];
    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [2:0]        r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != 3'd0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= {INST_W{1'b0}};
                r_pc[i]   <= {ADDR_W{1'b0}};
            end
        end else if (i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= 3'd0;
        end else begin
            if (w_do_push) begin
                r_inst[r_wr_ptr] <= i_push_inst;
                r_pc[r_wr_ptr]   <= i_push_pc;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head view is forced to zero while the buffer is empty.
    always_comb begin
        o_head_inst = {INST_W{1'b0}};
        o_head_pc   = {ADDR_W{1'b0}};
        if (r_count != 3'd0) begin
            o_head_inst = r_inst[r_rd_ptr];
            o_head_pc   = r_pc[r_rd_ptr];
        end else begin
            o_head_inst = {INST_W{1'b0}};
            o_head_pc   = {ADDR_W{1'b0}};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/FULL sequencer feeding a prefetch FIFO.
// Define FETCH_PERF_EN to add the saturating perf_fetched counter port.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
)
(
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
`ifdef FETCH_PERF_EN
    output logic [15:0]       perf_fetched,
`endif
    output logic [ADDR_W-1:0] pc_out
);

    localparam logic [2:0] LAST_FREE = 3'(DEPTH - 1);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_fpc;
    logic              r_req;
    logic [2:0]        w_count;
    logic              w_redirect;
    logic              w_push;
    logic              w_pop;

    // A redirect in IDLE is ignored; otherwise it wins over any ack.
    assign w_redirect = redirect && (r_state != IDLE);
    assign w_push     = (r_state == FETCH) && imem_ack && !w_redirect;
    assign w_pop      = inst_valid && inst_ready;

    // Fetch sequencer: state, fetch pc and the registered request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_fpc   <= RESET_PC;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: begin
                    if (w_redirect) begin
                        r_fpc   <= align_addr(redirect_addr);
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end else if (w_push) begin
                        r_fpc <= next_pc(r_fpc);
                        if (!w_pop && (w_count == LAST_FREE)) begin
                            r_state <= FULL;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= FETCH;
                            r_req   <= 1'b1;
                        end
                    end else begin
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end
                end
                FULL: begin
                    if (w_redirect) begin
                        r_fpc   <= align_addr(redirect_addr);
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end else if (w_pop) begin
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end else begin
                        r_state <= FULL;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .i_rst_n    (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (w_redirect),
        .i_push_inst(imem_data),
        .i_push_pc  (r_fpc),
        .o_count    (w_count),
        .o_head_inst(inst_out),
        .o_head_pc  (pc_out)
    );

    assign imem_req   = r_req;
    assign imem_addr  = r_fpc;
    assign inst_valid = (w_count != 3'd0);

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf;

    // Accepted-fetch counter: saturates, and is not cleared by redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf <= 16'd0;
        end else if (w_push && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end else begin
            r_perf <= r_perf;
        end
    end

    assign perf_fetched = r_perf;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a transaction-level fetch model predicts
// request/address per cycle and the FIFO of delivered instructions.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [7:0] RST_PC = 8'h00;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [7:0]  pc_out;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
`endif

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_out     (inst_out),
`ifdef FETCH_PERF_EN
        .perf_fetched (perf_fetched),
`endif
        .pc_out       (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  pc;
    } ent_t;

    ent_t       q[$];
    ent_t       pend;
    bit         pend_v;
    bit         flush_p;
    bit         m_idle;
    bit         mon_en;
    logic [7:0] m_fpc;
    int         m_fetched;
    int         errors;
    int         checks;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Asynchronous reset applied between clock edges, then released after an edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        mon_en = 1'b0;
        imem_ack = 1'b0;
        redirect = 1'b0;
        inst_ready = 1'b0;
        #1;
        chk("rst_req", imem_req, 40'd0);
        chk("rst_valid", inst_valid, 40'd0);
        chk("rst_inst", inst_out, 40'd0);
        chk("rst_pc", pc_out, 40'd0);
        chk("rst_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_EN
        chk("rst_perf", perf_fetched, 40'd0);
`endif
        q.delete();
        pend_v = 1'b0;
        flush_p = 1'b0;
        m_fpc = RST_PC;
        m_idle = 1'b1;
        m_fetched = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic cycle(input bit ack, input bit red, input logic [7:0] raddr, input bit rdy);
        bit req_exp;
        if (flush_p) q.delete();
        if (pend_v) q.push_back(pend);
        flush_p = 1'b0;
        pend_v = 1'b0;
        req_exp = !m_idle && (q.size() < DEPTH);
        chk("imem_req", imem_req, req_exp);
        chk("imem_addr", imem_addr, m_fpc);
        imem_ack = ack;
        imem_data = $urandom;
        redirect = red;
        redirect_addr = raddr;
        inst_ready = rdy;
        if (red && !m_idle) begin
            flush_p = 1'b1;
            m_fpc = {raddr[7:2], 2'b00};
        end else if (ack && req_exp) begin
            pend = '{inst: imem_data, pc: m_fpc};
            pend_v = 1'b1;
            m_fpc = m_fpc + 8'd4;
            m_fetched++;
        end
        m_idle = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle compare of the DUT head against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            chk("inst_valid", inst_valid, (q.size() != 0));
            if (q.size() != 0) begin
                chk("inst_out", inst_out, q[0].inst);
                chk("pc_out", pc_out, q[0].pc);
                if (inst_ready) void'(q.pop_front());
            end else begin
                chk("empty_inst", inst_out, 40'd0);
                chk("empty_pc", pc_out, 40'd0);
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        mon_en = 1'b0;
        imem_ack = 1'b0;
        imem_data = 32'd0;
        redirect = 1'b0;
        redirect_addr = 8'd0;
        inst_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset release with ack tied high; redirect in IDLE is ignored.
        do_reset();
        chk("idle_req", imem_req, 40'd0);
        cycle(1'b1, 1'b1, 8'h80, 1'b1);
        chk("first_addr", imem_addr, 40'h00);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        chk("valid_lat", inst_valid, 40'd1);
        chk("addr04", imem_addr, 40'h04);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        chk("addr08", imem_addr, 40'h08);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Fill with the consumer stalled, then one pop.
        do_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("full_req", imem_req, 40'd0);
        chk("full_head", pc_out, 40'h00);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("refill_req", imem_req, 40'd1);
        chk("refill_addr", imem_addr, 40'h08);

        // Redirect with a concurrent ack while one entry is buffered.
        cycle(1'b1, 1'b1, 8'h43, 1'b0);
        chk("redir_valid", inst_valid, 40'd0);
        chk("redir_addr", imem_addr, 40'h40);

        // Wait states at 0C.
        cycle(1'b0, 1'b1, 8'h0C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            chk("wait_addr", imem_addr, 40'h0C);
            chk("wait_req", imem_req, 40'd1);
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("wait_push_pc", pc_out, 40'h0C);

        // Address wrap at FC, reached through an unaligned target.
        cycle(1'b0, 1'b1, 8'hFE, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("wrap_pc", pc_out, 40'hFC);
        chk("wrap_addr", imem_addr, 40'h00);

`ifdef FETCH_PERF_EN
        do_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 8'h20, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        chk("perf7", perf_fetched, 40'd7);
`endif

        // Randomized traffic with one asynchronous reset mid-stream.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
                  8'($urandom), ($urandom_range(0, 1) == 1));
`ifdef FETCH_PERF_EN
            if ((i % 100) == 99) chk("perf_rand", perf_fetched, 40'(m_fetched));
`endif
        end

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
